// File: rtl/sa_instruction_issuer_if.sv
// sa_instruction_issuer_if: host-side valid/ready instruction bus into the issuer
interface sa_instruction_issuer_if #(
    parameter int OPCODE_BITS = 4,
    parameter int ADDR_BITS   = 8,
    parameter int DIN_BITS    = 128
);
    logic                   s_valid;
    logic                   s_ready;
    logic [OPCODE_BITS-1:0] s_opcode;
    logic [ADDR_BITS-1:0]   s_addra;
    logic [ADDR_BITS-1:0]   s_addrb;
    logic [DIN_BITS-1:0]    s_din;

    modport master (output s_valid, s_opcode, s_addra, s_addrb, s_din, input s_ready);
    modport slave  (input s_valid, s_opcode, s_addra, s_addrb, s_din, output s_ready);
endinterface

// File: rtl/sa_instruction_issuer.sv
// sa_instruction_issuer: buffers host instructions and holds each on the systolic array bus for its opcode's cycle count
module sa_instruction_issuer #(
    parameter int OPCODE_BITS      = 4,
    parameter int ADDR_BITS        = 8,
    parameter int DIN_BITS         = 128,
    parameter int DOUT_BITS        = 320,
    parameter int FIFO_DEPTH       = 4,
    parameter int WRITE_WEIGHT_CYC = 1,
    parameter int LOAD_WEIGHT_CYC  = 2,
    parameter int MAT_MUL_CYC      = 33,
    parameter int WRITE_RESULT_CYC = 2,
    parameter int READ_UB_CYC      = 2
) (
    input  logic                               clk,
    input  logic                               reset_n,
    sa_instruction_issuer_if.slave             host,
    output logic [OPCODE_BITS+2*ADDR_BITS-1:0] instruction,
    output logic [DIN_BITS-1:0]                din,
    input  logic [DOUT_BITS-1:0]               dout,
    output logic                               rd_valid,
    output logic [DOUT_BITS-1:0]               rd_data,
    output logic                               busy,
    output logic                               err_opcode
);
    localparam int IW       = OPCODE_BITS + 2*ADDR_BITS;
    localparam int ENT_BITS = IW + DIN_BITS;
    localparam int PW       = $clog2(FIFO_DEPTH);
    localparam int M1       = WRITE_WEIGHT_CYC > LOAD_WEIGHT_CYC ? WRITE_WEIGHT_CYC : LOAD_WEIGHT_CYC;
    localparam int M2       = MAT_MUL_CYC > WRITE_RESULT_CYC ? MAT_MUL_CYC : WRITE_RESULT_CYC;
    localparam int M3       = M1 > M2 ? M1 : M2;
    localparam int MAX_CYC  = M3 > READ_UB_CYC ? M3 : READ_UB_CYC;
    localparam int CW       = MAX_CYC > 1 ? $clog2(MAX_CYC) : 1;

    typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

    logic [ENT_BITS-1:0]    mem [FIFO_DEPTH];
    logic [PW:0]            wr_ptr, rd_ptr, count;
    logic                   full, empty, push, pop, head_ok, last_rub;
    logic [ENT_BITS-1:0]    head;
    logic [OPCODE_BITS-1:0] head_op;
    logic [CW-1:0]          head_hold, cnt;
    state_t                 state;

    assign count        = wr_ptr - rd_ptr;
    assign full         = count == (PW+1)'(FIFO_DEPTH);
    assign empty        = count == '0;
    assign host.s_ready = !full;
    assign push         = host.s_valid && !full;
    assign pop          = !empty && (state == ST_IDLE || cnt == '0);
    assign head         = mem[rd_ptr[PW-1:0]];
    assign head_op      = head[ENT_BITS-1 -: OPCODE_BITS];
    assign head_ok      = head_op <= OPCODE_BITS'(8);
    assign last_rub     = state == ST_ISSUE && cnt == '0 && instruction[IW-1 -: OPCODE_BITS] == OPCODE_BITS'(8);

    // hold count minus one for the entry at the FIFO head; single-cycle and undefined opcodes load 0
    always_comb
        head_hold = head_op == OPCODE_BITS'(2) ? CW'(WRITE_WEIGHT_CYC-1) :
                    head_op == OPCODE_BITS'(4) ? CW'(LOAD_WEIGHT_CYC-1) :
                    (head_op == OPCODE_BITS'(5) || head_op == OPCODE_BITS'(6)) ? CW'(MAT_MUL_CYC-1) :
                    head_op == OPCODE_BITS'(7) ? CW'(WRITE_RESULT_CYC-1) :
                    head_op == OPCODE_BITS'(8) ? CW'(READ_UB_CYC-1) : '0;

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk)
        if (push) mem[wr_ptr[PW-1:0]] <= {host.s_opcode, host.s_addra, host.s_addrb, host.s_din};

    // FIFO pointers with an extra MSB so full and empty are distinguishable
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end

    // issue FSM: pops the head, holds it for its cycle count, chains directly into the next entry
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state       <= ST_IDLE;
            instruction <= '0;
            din         <= '0;
            cnt         <= '0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            busy        <= 1'b0;
            err_opcode  <= 1'b0;
        end else begin
            busy     <= state == ST_ISSUE || !empty;
            rd_valid <= last_rub;
            if (last_rub) rd_data <= dout;
            if (pop) begin
                state       <= ST_ISSUE;
                instruction <= head_ok ? head[ENT_BITS-1 -: IW] : '0;
                din         <= head[DIN_BITS-1:0];
                cnt         <= head_hold;
                if (!head_ok) err_opcode <= 1'b1;
            end else if (state == ST_ISSUE) begin
                if (cnt == '0) begin
                    state       <= ST_IDLE;
                    instruction <= '0;
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end
        end
endmodule

// File: tb/tb_sa_instruction_issuer.sv
// tb_sa_instruction_issuer: directed checks of issue timing, FIFO flow control, read-back capture and error flag
module tb_sa_instruction_issuer;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [19:0]  instruction;
    logic [127:0] din;
    logic [319:0] dout, rd_data;
    logic         rd_valid, busy, err_opcode;
    logic [127:0] wd;
    int           errors = 0, checks = 0, mm_cnt = 0;

    always #5 clk = ~clk;

    sa_instruction_issuer_if #(.OPCODE_BITS(4), .ADDR_BITS(8), .DIN_BITS(128)) host();

    sa_instruction_issuer dut (
        .clk(clk), .reset_n(reset_n), .host(host),
        .instruction(instruction), .din(din), .dout(dout),
        .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .err_opcode(err_opcode)
    );

    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] ins(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        return {op, a, b};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [127:0] d);
        host.s_valid  = v;
        host.s_opcode = op;
        host.s_addra  = a;
        host.s_addrb  = b;
        host.s_din    = d;
    endtask

    task automatic step(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [127:0] d);
        drive(1'b1, op, a, b, d);
        tick;
        host.s_valid = 1'b0;
    endtask

    initial begin
        drive(1'b0, 4'd0, 8'd0, 8'd0, 128'd0);
        dout = '0;
        tick;
        tick;
        check("rst_instr", instruction, 0);
        check("rst_din", din, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_err", err_opcode, 0);
        check("rst_ready", host.s_ready, 1);
        reset_n = 1'b1;
        tick;

        for (int j = 0; j < 16; j++) wd[j*8 +: 8] = 8'(5 - j);
        step(4'd1, 8'h05, 8'h33, wd);
        check("wd_not_yet", instruction, 0);
        tick;
        check("wd_instr", instruction, ins(1, 8'h05, 8'h33));
        check("wd_din", din, wd);
        tick;
        check("wd_back_idle", instruction, 0);
        check("wd_din_hold", din, wd);

        step(4'd5, 8'h01, 8'h02, 128'h1);
        tick;
        check("mm_start", instruction, ins(5, 8'h01, 8'h02));
        for (int i = 0; i < 4; i++) step(4'd5, 8'h01, 8'(3 + i), 128'h2);
        check("mm_fifo_full", host.s_ready, 0);
        repeat (5) tick;
        check("mm_cycle10", instruction, ins(5, 8'h01, 8'h02));
        reset_n = 1'b0;
        #1;
        check("mm_rst_instr", instruction, 0);
        check("mm_rst_busy", busy, 0);
        check("mm_rst_fifo_empty", host.s_ready, 1);
        tick;
        reset_n = 1'b1;
        tick;
        step(4'd7, 8'h44, 8'h55, 128'hBEEF);
        tick;
        check("post_rst_wr0", instruction, ins(7, 8'h44, 8'h55));
        check("post_rst_din", din, 128'hBEEF);
        tick;
        check("post_rst_wr1", instruction, ins(7, 8'h44, 8'h55));
        tick;
        check("post_rst_idle", instruction, 0);

        step(4'd4, 8'h10, 8'd0, 128'h0);
        check("lw_not_yet", instruction, 0);
        step(4'd4, 8'h10, 8'd1, 128'h1);
        check("lw_b0_c0", instruction, ins(4, 8'h10, 8'd0));
        step(4'd4, 8'h10, 8'd2, 128'h2);
        check("lw_b0_c1", instruction, ins(4, 8'h10, 8'd0));
        for (int k = 0; k < 4; k++) begin
            tick;
            check("lw_seq", instruction, ins(4, 8'h10, 8'(1 + k/2)));
        end
        tick;
        check("lw_done", instruction, 0);

        step(4'd5, 8'h20, 8'd0, 128'h0);
        for (int i = 1; i <= 4; i++) begin
            step(4'd5, 8'h20, 8'(i), 128'(i));
            if (instruction[19:16] == 4'd5) mm_cnt++;
        end
        drive(1'b1, 4'd5, 8'h20, 8'd5, 128'h5);
        #1;
        check("ff_ready_5th", host.s_ready, 0);
        host.s_valid = 1'b0;
        for (int e = 6; e < 400; e++) begin
            tick;
            if (e == 34) check("ff_ready_before_pop", host.s_ready, 0);
            if (e == 35) check("ff_ready_after_pop", host.s_ready, 1);
            if (e == 100) check("ff_busy", busy, 1);
            if (instruction[19:16] != 4'd5) break;
            mm_cnt++;
        end
        check("ff_mm_cycles", 320'(mm_cnt), 320'd165);
        check("ff_end_idle", instruction, 0);
        tick;
        check("ff_busy_clear", busy, 0);

        dout = 320'h11;
        step(4'd8, 8'h07, 8'd3, 128'h0);
        tick;
        check("rub_c0", instruction, ins(8, 8'h07, 8'd3));
        tick;
        check("rub_c1", instruction, ins(8, 8'h07, 8'd3));
        check("rub_no_early_valid", rd_valid, 0);
        dout = 320'hA5;
        tick;
        check("rub_valid", rd_valid, 1);
        check("rub_data", rd_data, 320'hA5);
        check("rub_idle", instruction, 0);
        dout = 320'h77;
        tick;
        check("rub_valid_pulse", rd_valid, 0);
        check("rub_data_held", rd_data, 320'hA5);

        check("err_pre", err_opcode, 0);
        step(4'd12, 8'h01, 8'h02, 128'h0);
        step(4'd1, 8'h09, 8'h0A, 128'h3);
        check("err_instr_zero", instruction, 0);
        check("err_set", err_opcode, 1);
        tick;
        check("err_next_instr", instruction, ins(1, 8'h09, 8'h0A));
        check("err_sticky1", err_opcode, 1);
        tick;
        check("err_idle", instruction, 0);
        check("err_sticky2", err_opcode, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
